// File: rtl/mvm_8_1_12_1.sv
// rtl/mvm_8_1_12_1.sv - serial-load signed matrix-vector multiplier, y = A*x, single MAC
module mvm_8_1_12_1 #(
  parameter int K = 8,   // matrix dimension
  parameter int P = 1,   // parallel MAC units (datapath below is the P=1 case)
  parameter int B = 12,  // input element width; results are 2*B wide
  parameter int G = 1    // 1: register the multiplier output before accumulation
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadMatrix,
  input  logic                  loadVector,
  input  logic                  start,
  output logic                  done,
  input  logic signed [B-1:0]   data_in,
  output logic signed [2*B-1:0] data_out
);

  localparam int IW = $clog2(K*K);
  localparam int KW = $clog2(K);
  localparam int CW = $clog2(K*K/P + 5);

  // COMPUTE lasts a fixed K*K/P + 4 cycles so done lands at a fixed offset from start
  localparam logic [CW-1:0] M_LAST = CW'(K*K - 1);
  localparam logic [CW-1:0] V_LAST = CW'(K - 1);
  localparam logic [CW-1:0] N_MACS = CW'(K*K/P);
  localparam logic [CW-1:0] C_LAST = CW'(K*K/P + 3);
  localparam logic [CW-1:0] O_LAST = CW'(K - 1);

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, DONE, OUT} state_t;

  state_t state, next, cmd_next;
  logic [CW-1:0] cnt;

  // operand storage deliberately survives reset
  logic signed [B-1:0]   a_mem [K*K];
  logic signed [B-1:0]   x_mem [K];
  logic signed [2*B-1:0] outbuf [K];
  logic signed [2*B-1:0] acc;

  logic                  mac_en;
  logic [IW-1:0]         idx;
  logic signed [2*B-1:0] prod_d;
  logic                  acc_v;
  logic [IW-1:0]         acc_idx;
  logic signed [2*B-1:0] acc_p;
  logic signed [2*B-1:0] acc_sum;

  // command decode shared by IDLE and the last output cycle
  always_comb begin
    cmd_next = IDLE;
    if (loadMatrix)      cmd_next = LOAD_M;
    else if (loadVector) cmd_next = LOAD_V;
    else if (start)      cmd_next = COMPUTE;
  end

  // next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = cmd_next;
      LOAD_M:  if (cnt == M_LAST) next = IDLE;
      LOAD_V:  if (cnt == V_LAST) next = IDLE;
      COMPUTE: if (cnt == C_LAST) next = DONE;
      DONE:    next = OUT;
      OUT:     if (cnt == O_LAST) next = cmd_next;
      default: next = IDLE;
    endcase
  end

  // state register and the per-state cycle counter (restarts on every state change)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= (next == state && state != IDLE) ? cnt + 1'b1 : '0;
    end
  end

  // operand writes, row-major for the matrix
  always_ff @(posedge clk) begin
    if (state == LOAD_M) a_mem[cnt[IW-1:0]] <= data_in;
    if (state == LOAD_V) x_mem[cnt[KW-1:0]] <= data_in;
  end

  assign mac_en = (state == COMPUTE) && (cnt < N_MACS);
  assign idx    = cnt[IW-1:0];
  assign prod_d = (2*B)'(a_mem[idx]) * (2*B)'(x_mem[idx[KW-1:0]]);

  generate
    if (G != 0) begin : g_preg
      // product pipeline register with its element index
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_v   <= 1'b0;
          acc_idx <= '0;
          acc_p   <= '0;
        end else begin
          acc_v   <= mac_en;
          acc_idx <= idx;
          acc_p   <= prod_d;
        end
      end
    end else begin : g_pcomb
      assign acc_v   = mac_en;
      assign acc_idx = idx;
      assign acc_p   = prod_d;
    end
  endgenerate

  assign acc_sum = acc + acc_p;

  // accumulate; at the last column bank the row sum and clear for the next row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      for (int i = 0; i < K; i++) outbuf[i] <= '0;
    end else if (acc_v) begin
      if (&acc_idx[KW-1:0]) begin
        outbuf[acc_idx[IW-1:KW]] <= acc_sum;
        acc <= '0;
      end else begin
        acc <= acc_sum;
      end
    end
  end

  assign done     = (state == DONE);
  assign data_out = (state == OUT) ? outbuf[cnt[KW-1:0]] : '0;

endmodule

// File: tb/tb_mvm_8_1_12_1.sv
// tb/tb_mvm_8_1_12_1.sv - scoreboard bench for mvm_8_1_12_1
module tb_mvm_8_1_12_1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               loadMatrix = 1'b0;
  logic               loadVector = 1'b0;
  logic               start = 1'b0;
  logic               done;
  logic signed [11:0] data_in = '0;
  logic signed [23:0] data_out;

  int checks = 0;
  int errors = 0;

  int ma [64];
  int mx [8];
  int new_a [64];
  int new_x [8];
  int exp_q [$];

  mvm_8_1_12_1 dut (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
    .start(start), .done(done), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // each task starts and ends 1ns after a rising edge with inputs idle
  task automatic load_m(input int inj_v);
    loadMatrix = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(posedge clk); #1;
      loadMatrix = 1'b0;
      loadVector = (n == inj_v);
      data_in = 12'(new_a[n]);
      ma[n] = new_a[n];
    end
    @(posedge clk); #1;
    loadVector = 1'b0;
    data_in = '0;
  endtask

  task automatic load_v();
    loadVector = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      loadVector = 1'b0;
      data_in = 12'(new_x[n]);
      mx[n] = new_x[n];
    end
    @(posedge clk); #1;
    data_in = '0;
  endtask

  task automatic push_expected();
    for (int r = 0; r < 8; r++) begin
      int s;
      logic signed [23:0] t;
      s = 0;
      for (int k = 0; k < 8; k++) s += ma[r*8+k] * mx[k];
      t = s[23:0];
      exp_q.push_back(int'(t));
    end
  endtask

  task automatic run(input string tag, input int inj_start, input int inj_lm);
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 68; k++) begin
      @(posedge clk); #1;
      start = (k == inj_start);
      check({tag, "_done"}, int'(done), (k == 68) ? 1 : 0);
      if (k == 20 || k == 68) check({tag, "_idle_out"}, int'(data_out), 0);
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      loadMatrix = (i == inj_lm);
      check({tag, "_done_low"}, int'(done), 0);
      if (exp_q.size() > 0) check({tag, "_y"}, int'(data_out), exp_q.pop_front());
      else check({tag, "_queue_empty"}, 1, 0);
    end
    loadMatrix = 1'b0;
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    check("reset_done", int'(done), 0);
    check("reset_out", int'(data_out), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ramp matrix and offset vector
    for (int n = 0; n < 64; n++) new_a[n] = n - 32;
    for (int k = 0; k < 8; k++) new_x[k] = k - 4;
    load_m(-1);
    load_v();
    run("ramp", -1, -1);

    // identity passes x through, sign-extended
    for (int n = 0; n < 64; n++) new_a[n] = (n / 8 == n % 8) ? 1 : 0;
    new_x = '{1023, -1024, 5, -5, 0, 1, -1, 7};
    load_m(-1);
    load_v();
    run("ident", -1, -1);

    // extremes: wrap to -8388608, then -8380416 per row
    for (int n = 0; n < 64; n++) new_a[n] = -1024;
    for (int k = 0; k < 8; k++) new_x[k] = -1024;
    load_m(-1);
    load_v();
    run("ext_neg", -1, -1);
    check("ext_model_wrap", exp_q.size(), 0);
    for (int n = 0; n < 64; n++) new_a[n] = 1023;
    load_m(-1);
    run("ext_mix", -1, -1);

    // back-to-back random operands, command right after last output
    for (int n = 0; n < 64; n++) new_a[n] = $signed(12'($urandom));
    for (int k = 0; k < 8; k++) new_x[k] = $signed(12'($urandom));
    load_m(-1);
    load_v();
    run("b2b_a", -1, -1);
    for (int n = 0; n < 64; n++) new_a[n] = $signed(12'($urandom));
    load_m(-1);
    run("b2b_b", -1, -1);

    // reset keeps operands
    reset = 1'b1;
    #2;
    check("midreset_done", int'(done), 0);
    check("midreset_out", int'(data_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run("post_reset", -1, -1);

    // ignored commands in busy states
    for (int n = 0; n < 64; n++) new_a[n] = $signed(12'($urandom));
    load_m(10);
    run("ignore", 10, 3);
    run("ignore_again", -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
